// File: rtl/pool_collector_if.sv
// Stream-in / read-out bundle between the pooler, the collector and its consumer.
// master = pooler and reader side, slave = the collector.
interface pool_collector_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             end_in;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_last;

    modport master (
        output data_in, valid_in, end_in, rd_en,
        input  rd_data, rd_valid, rd_last
    );

    modport slave (
        input  data_in, valid_in, end_in, rd_en,
        output rd_data, rd_valid, rd_last
    );
endinterface

// File: rtl/pool_collector.sv
// Captures one (M/P)x(M/P) pooled frame in raster order, then serves it
// through a registered read port before returning to capture mode.
module pool_collector #(
    parameter int  WIDTH = 32,
    parameter int  M     = 12,
    parameter int  P     = 3,
    localparam int DEPTH = (M / P) * (M / P),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 master_rst,
    pool_collector_if.slave      bus,
    output logic                 frame_ready,
    output logic [CW-1:0]        word_count,
    output logic                 frame_err,
    output logic                 overflow_err
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {COLLECT, READY} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    count_after;
    logic             full;
    logic             store_en;
    logic             drop;
    logic             rd_fire;
    logic             rd_is_last;
    logic             short_frame;

    assign full        = (word_count == DEPTH_C);
    assign count_after = word_count + CW'(store_en);
    assign short_frame = (count_after < DEPTH_C);
    // An empty frame still yields one read, flagged last.
    assign rd_is_last  = (word_count == '0) || (rd_ptr == (word_count - CW'(1)));

    always_ff @(posedge clk) begin
        if (master_rst) state <= COLLECT;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (bus.end_in) state_nxt = READY;
            READY:   if (rd_fire && rd_is_last) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        store_en    = 1'b0;
        drop        = 1'b0;
        rd_fire     = 1'b0;
        frame_ready = 1'b0;
        case (state)
            COLLECT: begin
                store_en = bus.valid_in && !full;
                drop     = bus.valid_in && full;
            end
            READY: begin
                frame_ready = 1'b1;
                drop        = bus.valid_in;
                rd_fire     = bus.rd_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!master_rst && store_en) mem[word_count[AW-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            word_count   <= '0;
            rd_ptr       <= '0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
            frame_err    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            bus.rd_valid <= rd_fire;
            bus.rd_last  <= rd_fire && rd_is_last;
            if (store_en) word_count <= count_after;
            if (drop) overflow_err <= 1'b1;
            if (state == COLLECT && bus.end_in && short_frame) frame_err <= 1'b1;
            if (rd_fire) begin
                bus.rd_data <= (word_count == '0) ? '0 : mem[rd_ptr[AW-1:0]];
                if (rd_is_last) begin
                    rd_ptr     <= '0;
                    word_count <= '0;
                end else begin
                    rd_ptr <= rd_ptr + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_collector.sv
// Bench for pool_collector: fixed vector table, directed frame sequences and
// random traffic, all compared against a queue-based model of the frame store.
module tb_pool_collector;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          master_rst = 1'b0;
    logic          frame_ready;
    logic [CW-1:0] word_count;
    logic          frame_err;
    logic          overflow_err;

    pool_collector_if #(.WIDTH(WIDTH)) bus ();

    pool_collector #(.WIDTH(WIDTH), .M(12), .P(3)) dut (
        .clk          (clk),
        .master_rst   (master_rst),
        .bus          (bus.slave),
        .frame_ready  (frame_ready),
        .word_count   (word_count),
        .frame_err    (frame_err),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame is a queue of words, read back by index.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ready;
    bit               m_ferr;
    bit               m_ovf;
    bit               m_rv;
    bit               m_rl;
    logic [WIDTH-1:0] m_rdata;
    int               m_rd;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             e;
        logic             r;
        logic             fr;
        logic [CW-1:0]    wc;
        logic             rv;
        logic             rl;
        logic [WIDTH-1:0] rdd;
        logic             fe;
        logic             ov;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("frame_ready", 32'(frame_ready), 32'(m_ready));
        chk("word_count", 32'(word_count), 32'(m_q.size()));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        chk("rd_last", 32'(bus.rd_last), 32'(m_rl));
        chk("rd_data", bus.rd_data, m_rdata);
    endtask

    task automatic model_update(input logic v, input logic [WIDTH-1:0] d, input logic e, input logic r);
        int n;
        m_rv = 1'b0;
        m_rl = 1'b0;
        if (!m_ready) begin
            if (v) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            if (e) begin
                if (m_q.size() < DEPTH) m_ferr = 1'b1;
                m_ready = 1'b1;
            end
        end else begin
            if (v) m_ovf = 1'b1;
            if (r) begin
                n       = m_q.size();
                m_rv    = 1'b1;
                m_rdata = (n == 0) ? '0 : m_q[m_rd];
                m_rl    = (n == 0) || (m_rd == n - 1);
                m_rd++;
                if (m_rl) begin
                    m_q.delete();
                    m_rd    = 0;
                    m_ready = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic e, input logic r);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.end_in   = e;
        bus.rd_en    = r;
        @(posedge clk);
        model_update(v, d, e, r);
        @(negedge clk);
        chk_model();
    endtask

    // Inputs are all asserted during reset to show reset takes priority.
    task automatic do_reset();
        master_rst   = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 32'hDEAD_BEEF;
        bus.end_in   = 1'b1;
        bus.rd_en    = 1'b1;
        @(posedge clk);
        m_q.delete();
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_ovf   = 1'b0;
        m_rv    = 1'b0;
        m_rl    = 1'b0;
        m_rdata = '0;
        m_rd    = 0;
        @(negedge clk);
        master_rst = 1'b0;
        chk_model();
    endtask

    task automatic send_frame(input int n, input int base, input bit end_with_last);
        for (int i = 0; i < n; i++)
            step(1'b1, WIDTH'(base + i), (end_with_last && i == n - 1) ? 1'b1 : 1'b0, 1'b0);
        if (!end_with_last) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            chk("drain_valid", 32'(bus.rd_valid), 32'd1);
            chk("drain_data", bus.rd_data, WIDTH'(base + i));
            chk("drain_last", 32'(bus.rd_last), (i == n - 1) ? 32'd1 : 32'd0);
        end
        chk("drain_done_ready", 32'(frame_ready), 32'd0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.end_in   = 1'b0;
        bus.rd_en    = 1'b0;

        //            v     d       e     r     fr    wc     rv    rl    rdd     fe    ov
        tbl[0]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 32'hA1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 32'hA2, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 32'hA5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'hA3, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'hA3, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'hA3, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0,  1'b1, 1'b1};
        tbl[10] = '{1'b1, 32'hA6, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1};

        @(negedge clk);
        do_reset();
        chk("rst_ready", 32'(frame_ready), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].r);
            chk($sformatf("tbl%0d_fr", i), 32'(frame_ready), 32'(tbl[i].fr));
            chk($sformatf("tbl%0d_wc", i), 32'(word_count), 32'(tbl[i].wc));
            chk($sformatf("tbl%0d_rv", i), 32'(bus.rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rl", i), 32'(bus.rd_last), 32'(tbl[i].rl));
            chk($sformatf("tbl%0d_rdd", i), bus.rd_data, tbl[i].rdd);
            chk($sformatf("tbl%0d_fe", i), 32'(frame_err), 32'(tbl[i].fe));
            chk($sformatf("tbl%0d_ov", i), 32'(overflow_err), 32'(tbl[i].ov));
        end

        // Full frame, end_in with the last word
        do_reset();
        send_frame(16, 1, 1'b1);
        chk("full_ready", 32'(frame_ready), 32'd1);
        chk("full_count", 32'(word_count), 32'd16);
        chk("full_ferr", 32'(frame_err), 32'd0);
        chk("full_ovf", 32'(overflow_err), 32'd0);
        drain(16, 1);

        // Short frame, end_in alone
        do_reset();
        send_frame(10, 1, 1'b0);
        chk("short_ferr", 32'(frame_err), 32'd1);
        chk("short_count", 32'(word_count), 32'd10);
        drain(10, 1);

        // Overfilled frame
        do_reset();
        send_frame(17, 1, 1'b0);
        chk("over_ovf", 32'(overflow_err), 32'd1);
        chk("over_count", 32'(word_count), 32'd16);
        drain(16, 1);

        // Reset mid-frame, then a clean frame
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
        do_reset();
        chk("midrst_count", 32'(word_count), 32'd0);
        chk("midrst_valid", 32'(bus.rd_valid), 32'd0);
        chk("midrst_last", 32'(bus.rd_last), 32'd0);
        send_frame(16, 200, 1'b1);
        drain(16, 200);

        // Back-to-back frames
        do_reset();
        send_frame(16, 300, 1'b1);
        drain(16, 300);
        send_frame(16, 400, 1'b1);
        drain(16, 400);

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, $urandom(),
                     ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
